// File: rtl/spi_driver_if.sv
// rtl/spi_driver_if.sv - byte-stream handshake and SPI pin bundle for spi_driver
interface spi_driver_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       busy_o;
  logic       spi_sck_o;
  logic       spi_cs_no;
  logic       spi_tx_o;
  logic       spi_rx_i;

  modport master (
    output tx_valid_i, tx_data_i, tx_last_i, spi_rx_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, busy_o, spi_sck_o, spi_cs_no, spi_tx_o
  );

  modport slave (
    input  tx_valid_i, tx_data_i, tx_last_i, spi_rx_i,
    output tx_ready_o, rx_valid_o, rx_data_o, busy_o, spi_sck_o, spi_cs_no, spi_tx_o
  );
endinterface

// File: rtl/spi_driver.sv
// rtl/spi_driver.sv - mode-0 MSB-first SPI master framing a byte stream under one CS_N
module spi_driver #(
  parameter int CLK_MHZ = 64,
  parameter int SCK_MHZ = 24
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  spi_driver_if.slave bus
);

  localparam int HALF_RAW = (CLK_MHZ + 2 * SCK_MHZ - 1) / (2 * SCK_MHZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = $clog2(2 * HALF + 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * HALF - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, NEXT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          last_q;
  logic          tx_ready;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          busy;
  logic          sck;
  logic          cs_n;
  logic          pico;
  logic          cnt_done;
  logic          handshake;

  assign cnt_done  = (cnt == HALF_END);
  assign handshake = bus.tx_valid_i && tx_ready;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      last_q   <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      pico     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      cnt      <= cnt + 1'b1;
      unique case (state)
        IDLE, NEXT: begin
          // Loading straight into SETUP keeps the inter-byte gap to one setup period.
          if (handshake) begin
            tx_sr    <= bus.tx_data_i;
            last_q   <= bus.tx_last_i;
            pico     <= bus.tx_data_i[7];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            bit_cnt  <= '0;
            cnt      <= '0;
            state    <= SETUP;
          end else begin
            cnt <= '0;
          end
        end
        SETUP: begin
          if (cnt_done) begin
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[6:0], bus.spi_rx_i};
            bit_cnt <= bit_cnt + 1'b1;
            cnt     <= '0;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_done) begin
            sck <= 1'b0;
            cnt <= '0;
            if (bit_cnt == 4'd8) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sr;
              state    <= last_q ? HOLD : LOW;
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              pico  <= tx_sr[6];
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (cnt_done) begin
            cnt <= '0;
            if (bit_cnt == 4'd8) begin
              tx_ready <= 1'b1;
              state    <= NEXT;
            end else begin
              sck     <= 1'b1;
              rx_sr   <= {rx_sr[6:0], bus.spi_rx_i};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= HIGH;
            end
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cs_n  <= 1'b1;
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          // Minimum deselect time before another frame may start.
          if (cnt == GAP_END) begin
            pico     <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready_o = tx_ready;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_data_o  = rx_data;
  assign bus.busy_o     = busy;
  assign bus.spi_sck_o  = sck;
  assign bus.spi_cs_no  = cs_n;
  assign bus.spi_tx_o   = pico;

endmodule

// File: tb/tb_spi_driver.sv
// tb/tb_spi_driver.sv - scoreboard bench for spi_driver with loopback and slave model
`timescale 1ns/1ps
module tb_spi_driver;
  localparam int HALF = 2;
  localparam int TO   = 2000;

  logic clk_i = 1'b0;
  logic reset_ni;
  spi_driver_if bus();

  spi_driver #(.CLK_MHZ(64), .SCK_MHZ(24)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;
  int rd_idx = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  // Slave model: presents slave_byte MSB-first, advancing on each SCK falling edge.
  logic       loopback = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         sck_falls = 0;
  int         falls_at_cs = 0;
  logic [2:0] slave_idx;
  always @(negedge bus.spi_sck_o) sck_falls++;
  always @(negedge bus.spi_cs_no) falls_at_cs = sck_falls;
  assign slave_idx = 3'(7 - ((sck_falls - falls_at_cs) & 7));
  assign bus.spi_rx_i = loopback ? bus.spi_tx_o : slave_byte[slave_idx];

  int   cyc = 0, rise_cnt = 0, cs_rise_cnt = 0, rx_cnt = 0, byte_rises = 0, hi_run = 0;
  int   first_rise_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0, cs_rise_cyc = 0;
  int   bad_timing = 0, bad_tx = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_tx = 1'b0, cs_seen_rise = 1'b0;
  logic [7:0] tx_cap = 8'h00;
  logic [7:0] obs_rx[$];
  logic [7:0] obs_tx[$];

  always @(negedge clk_i) begin
    cyc++;
    if (!reset_ni) begin
      prev_sck = 1'b0; prev_cs = 1'b1; prev_tx = 1'b0;
      byte_rises = 0; hi_run = 0; cs_seen_rise = 1'b0;
    end else begin
      if (bus.spi_sck_o && !prev_sck) begin
        rise_cnt++;
        if (byte_rises == 0) first_rise_cyc = cyc;
        else if (cyc - last_rise_cyc != 2 * HALF) bad_timing++;
        last_rise_cyc = cyc;
        byte_rises++;
        tx_cap = {tx_cap[6:0], bus.spi_tx_o};
        if (bus.spi_cs_no) bad_tx++;
      end
      if (bus.spi_sck_o) hi_run++;
      if (!bus.spi_sck_o && prev_sck) begin
        last_fall_cyc = cyc;
        if (hi_run != HALF) bad_timing++;
        hi_run = 0;
      end
      if (bus.spi_sck_o && prev_sck && bus.spi_tx_o !== prev_tx) bad_tx++;
      if (bus.spi_cs_no && !prev_cs) begin
        cs_rise_cnt++;
        cs_rise_cyc = cyc;
        cs_seen_rise = 1'b1;
      end
      if (!bus.spi_cs_no && prev_cs && cs_seen_rise && (cyc - cs_rise_cyc < 2 * HALF)) bad_timing++;
      if (bus.rx_valid_o) begin
        rx_cnt++;
        obs_rx.push_back(bus.rx_data_o);
        obs_tx.push_back(tx_cap);
        byte_rises = 0;
      end
      prev_sck = bus.spi_sck_o;
      prev_cs  = bus.spi_cs_no;
      prev_tx  = bus.spi_tx_o;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input logic [7:0] er, output int hs);
    int t = 0;
    bus.tx_data_i = d; bus.tx_last_i = l; bus.tx_valid_i = 1'b1;
    while (!bus.tx_ready_o && t < TO) begin
      @(posedge clk_i); #1; t++;
    end
    if (t >= TO) begin
      n_vec++; n_miss++;
      $display("FAIL send_%02h: tx_ready_o=%b after %0d cycles, required 1", d, bus.tx_ready_o, TO);
    end else begin
      exp_tx_q.push_back(d);
      exp_rx_q.push_back(er);
    end
    @(posedge clk_i); #1;
    hs = cyc + 1;
    bus.tx_valid_i = 1'b0; bus.tx_data_i = 8'h00; bus.tx_last_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    while (bus.busy_o && t < TO) begin
      @(posedge clk_i); #1; t++;
    end
    ok = !bus.busy_o;
  endtask

  task automatic test_reset;
    reset_ni = 1'b0;
    bus.tx_valid_i = 1'b0; bus.tx_data_i = 8'h00; bus.tx_last_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if ({bus.spi_sck_o, bus.spi_cs_no, bus.spi_tx_o, bus.busy_o, bus.rx_valid_o} !== 5'b01000) begin
      n_miss++;
      $display("FAIL reset_pins: sck,cs_n,tx,busy,rx_valid=%b required 01000",
               {bus.spi_sck_o, bus.spi_cs_no, bus.spi_tx_o, bus.busy_o, bus.rx_valid_o});
    end
    n_vec++;
    if (bus.rx_data_o !== 8'h00) begin
      n_miss++; $display("FAIL reset_rx_data: got %02h required 00", bus.rx_data_o);
    end
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    n_vec++;
    if (bus.tx_ready_o !== 1'b1) begin
      n_miss++; $display("FAIL reset_ready: got %b required 1", bus.tx_ready_o);
    end
  endtask

  task automatic test_single;
    int r0 = rise_cnt, c0 = cs_rise_cnt, x0 = rx_cnt, bt0 = bad_timing, bx0 = bad_tx, hs;
    bit ok;
    logic [7:0] e, t;
    loopback = 1'b1;
    send_byte(8'hA5, 1'b1, 8'hA5, hs);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL single_idle: busy_o=%b after %0d cycles, required 0", bus.busy_o, TO); end
    n_vec++;
    if (rise_cnt - r0 != 8) begin n_miss++; $display("FAIL single_edges: got %0d rising edges required 8", rise_cnt - r0); end
    n_vec++;
    if (rx_cnt - x0 != 1) begin n_miss++; $display("FAIL single_strobes: got %0d required 1", rx_cnt - x0); end
    n_vec++;
    if (cs_rise_cnt - c0 != 1) begin n_miss++; $display("FAIL single_cs_rises: got %0d required 1", cs_rise_cnt - c0); end
    n_vec++;
    if (cs_rise_cyc - last_fall_cyc != HALF) begin
      n_miss++; $display("FAIL single_cs_hold: cs rose %0d cycles after last fall, required %0d", cs_rise_cyc - last_fall_cyc, HALF);
    end
    n_vec++;
    if ({bus.tx_ready_o, bus.spi_cs_no, bus.spi_tx_o, bus.spi_sck_o} !== 4'b1100) begin
      n_miss++; $display("FAIL single_after: ready,cs_n,tx,sck=%b required 1100",
                         {bus.tx_ready_o, bus.spi_cs_no, bus.spi_tx_o, bus.spi_sck_o});
    end
    n_vec++;
    if (bad_timing - bt0 != 0 || bad_tx - bx0 != 0) begin
      n_miss++; $display("FAIL single_shape: timing errors %0d, tx/cs errors %0d, required 0", bad_timing - bt0, bad_tx - bx0);
    end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL single_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL single_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL single_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_four_byte;
    logic [7:0] frame[4] = '{8'h40, 8'h01, 8'hE8, 8'h0F};
    int r0 = rise_cnt, c0 = cs_rise_cnt, x0 = rx_cnt, bt0 = bad_timing, bx0 = bad_tx, hs;
    bit ok;
    logic [7:0] e, t;
    loopback = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(frame[i], i == 3, frame[i], hs);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL four_idle: busy_o=%b after %0d cycles, required 0", bus.busy_o, TO); end
    n_vec++;
    if (rise_cnt - r0 != 32) begin n_miss++; $display("FAIL four_edges: got %0d required 32", rise_cnt - r0); end
    n_vec++;
    if (rx_cnt - x0 != 4) begin n_miss++; $display("FAIL four_strobes: got %0d required 4", rx_cnt - x0); end
    n_vec++;
    if (cs_rise_cnt - c0 != 1) begin n_miss++; $display("FAIL four_cs_rises: got %0d required 1", cs_rise_cnt - c0); end
    n_vec++;
    if (bad_timing - bt0 != 0 || bad_tx - bx0 != 0) begin
      n_miss++; $display("FAIL four_shape: timing errors %0d, tx/cs errors %0d, required 0", bad_timing - bt0, bad_tx - bx0);
    end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL four_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL four_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL four_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_stall;
    int r0, hs, w = 0;
    bit ok;
    logic [7:0] e, t;
    loopback = 1'b1;
    send_byte(8'h12, 1'b0, 8'h12, hs);
    while (!bus.tx_ready_o && w < TO) begin @(posedge clk_i); #1; w++; end
    n_vec++;
    if (w >= TO) begin n_miss++; $display("FAIL stall_next: tx_ready_o=%b after %0d cycles, required 1", bus.tx_ready_o, TO); end
    r0 = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (bus.spi_sck_o !== 1'b0 || bus.spi_cs_no !== 1'b0) begin
        n_miss++; $display("FAIL stall_hold[%0d]: sck=%b cs_n=%b required 0 0", i, bus.spi_sck_o, bus.spi_cs_no);
      end
    end
    n_vec++;
    if (rise_cnt != r0) begin n_miss++; $display("FAIL stall_edges: got %0d edges while stalled, required 0", rise_cnt - r0); end
    send_byte(8'h34, 1'b1, 8'h34, hs);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL stall_idle: busy_o=%b after %0d cycles, required 0", bus.busy_o, TO); end
    n_vec++;
    if (first_rise_cyc - hs != HALF) begin
      n_miss++; $display("FAIL stall_setup: first edge %0d cycles after load, required %0d", first_rise_cyc - hs, HALF);
    end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL stall_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL stall_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL stall_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_receive;
    int hs;
    bit ok;
    logic [7:0] e, t;
    loopback = 1'b0;
    slave_byte = 8'h3C;
    send_byte(8'h00, 1'b1, 8'h3C, hs);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL receive_idle: busy_o=%b after %0d cycles, required 0", bus.busy_o, TO); end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL receive_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL receive_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL receive_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
    loopback = 1'b1;
  endtask

  task automatic test_back_to_back;
    int c0 = cs_rise_cnt, x0 = rx_cnt, bt0 = bad_timing, hs;
    bit ok;
    logic [7:0] e, t;
    send_byte(8'hC3, 1'b1, 8'hC3, hs);
    send_byte(8'h5A, 1'b1, 8'h5A, hs);
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL b2b_idle: busy_o=%b after %0d cycles, required 0", bus.busy_o, TO); end
    n_vec++;
    if (cs_rise_cnt - c0 != 2 || rx_cnt - x0 != 2) begin
      n_miss++; $display("FAIL b2b_frames: cs rises %0d strobes %0d, required 2 2", cs_rise_cnt - c0, rx_cnt - x0);
    end
    n_vec++;
    if (bad_timing - bt0 != 0) begin n_miss++; $display("FAIL b2b_gap: %0d timing errors, required 0", bad_timing - bt0); end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL b2b_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL b2b_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL b2b_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int r0 = rise_cnt, x_abort, w = 0, hs;
    bit ok;
    logic [7:0] e, t;
    loopback = 1'b1;
    send_byte(8'h55, 1'b0, 8'h55, hs);
    send_byte(8'hAA, 1'b0, 8'hAA, hs);
    while (rise_cnt - r0 < 12 && w < TO) begin @(posedge clk_i); #1; w++; end
    n_vec++;
    if (w >= TO) begin n_miss++; $display("FAIL abort_reach: got %0d edges required 12", rise_cnt - r0); end
    x_abort = rx_cnt;
    #2 reset_ni = 1'b0;
    #1;
    n_vec++;
    if (bus.spi_cs_no !== 1'b1 || bus.spi_sck_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_miss++; $display("FAIL abort_async: cs_n=%b sck=%b busy=%b required 1 0 0", bus.spi_cs_no, bus.spi_sck_o, bus.busy_o);
    end
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++;
    if (rx_cnt != x_abort || bus.rx_valid_o !== 1'b0) begin
      n_miss++; $display("FAIL abort_no_strobe: got %0d strobes after abort, required 0", rx_cnt - x_abort);
    end
    e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
    n_vec++;
    if (rd_idx >= obs_rx.size() || obs_rx[rd_idx] !== e) begin
      n_miss++; $display("FAIL abort_first_byte: strobe missing or wrong, required %02h", e);
    end
    rd_idx = obs_rx.size();
    exp_rx_q.delete(); exp_tx_q.delete();
    r0 = rise_cnt;
    send_byte(8'h96, 1'b1, 8'h96, hs);
    wait_idle(ok);
    n_vec++;
    if (!ok || rise_cnt - r0 != 8) begin
      n_miss++; $display("FAIL fresh_edges: got %0d edges idle=%b, required 8 1", rise_cnt - r0, ok);
    end
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front(); t = exp_tx_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_rx.size()) begin n_miss++; $display("FAIL fresh_rx: no strobe, required %02h", e); end
      else begin
        if (obs_rx[rd_idx] !== e) begin n_miss++; $display("FAIL fresh_rx: got %02h required %02h", obs_rx[rd_idx], e); end
        n_vec++;
        if (obs_tx[rd_idx] !== t) begin n_miss++; $display("FAIL fresh_tx_bits: got %02h required %02h", obs_tx[rd_idx], t); end
        rd_idx++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_four_byte();
    test_stall();
    test_receive();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/spi_driver.md
Name:
spi_driver

Overview:
- Synthesizable SPI master (mode 0, MSB first) that turns a byte stream from a local controller into framed SPI transactions.
- Produces the SCK / CS_N / PICO stimulus used to drive the PET's SPI1 register/memory bus.
- A frame is a sequence of bytes, e.g. cmd, data, addr_hi, addr_lo. CS_N stays low for the whole frame and rises after the byte marked last.
- Every received byte is returned on a one-cycle strobe.

Parameters:
- CLK_MHZ, 64: clk_i frequency in MHz.
- SCK_MHZ, 24: maximum SCK rate in MHz.
- Derived HALF = max(1, ceil(CLK_MHZ / (2*SCK_MHZ))): SCK half-period in clk_i cycles. With the defaults HALF=2, giving a 16 MHz SCK.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- tx_valid_i  in  1  byte available on tx_data_i.
- tx_data_i  in  8  byte to transmit.
- tx_last_i  in  1  qualifies tx_data_i: this byte ends the frame.
- tx_ready_o  out  1  driver accepts a byte this cycle; transfer occurs when tx_valid_i && tx_ready_o.
- rx_valid_o  out  1  one-cycle strobe, rx_data_o valid.
- rx_data_o  out  8  byte received from spi_rx_i.
- busy_o  out  1  high whenever not in IDLE.
- spi_sck_o  out  1  SPI clock, idle low.
- spi_cs_no  out  1  chip select, active low.
- spi_tx_o  out  1  serial data out (PICO).
- spi_rx_i  in  1  serial data in (POCI).

Behaviour:
- Reset (async, reset_ni=0) forces state=IDLE and these outputs: spi_sck_o=0, spi_cs_no=1, spi_tx_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0. Asserting reset mid-frame aborts the frame immediately, and CS_N rises in the same instant. tx_ready_o=1 after release.
- States: IDLE, SETUP, HIGH, LOW, NEXT, HOLD, GAP. A counter times each HALF-cycle phase.
- IDLE: tx_ready_o=1. On handshake, latch the byte and the last flag, drive spi_cs_no=0 and spi_tx_o=bit7, then go to SETUP.
- SETUP: hold for HALF cycles (CS-to-first-edge setup), then go to HIGH.
- HIGH: spi_sck_o=1. Sample spi_rx_i into the shift register on entry (rising edge). Hold HALF cycles, then go to LOW.
- LOW: spi_sck_o=0. If bits remain, shift and present the next bit on spi_tx_o at the falling edge, hold HALF cycles, then go to HIGH.
- Byte completion, after 8 rising edges in LOW:
  - Pulse rx_valid_o for 1 cycle with rx_data_o = the 8 sampled bits (first sampled bit = MSB).
  - If last: go to HOLD.
  - Otherwise go to NEXT, after the LOW half-period elapses.
- NEXT: tx_ready_o=1, CS_N held low, SCK held low.
  - On handshake, load the byte, drive its bit7, and go to SETUP. This adds no extra gap beyond one SETUP.
  - Without a handshake, stall indefinitely; CS_N stays low.
- HOLD: SCK low, CS_N low for HALF cycles, then spi_cs_no=1 and go to GAP.
- GAP: CS_N high for 2*HALF cycles (minimum deselect time), then go to IDLE.
- tx_ready_o=0 in every state except IDLE and NEXT.
- Each byte produces exactly 8 SCK rising edges. SCK high and low phases are each exactly HALF cycles while shifting.
- spi_tx_o changes only while SCK is low. It keeps its last value after the frame and returns to 0 in IDLE.
- tx_data_i and tx_last_i are sampled only on a handshake. tx_valid_i is ignored in all other states.
- A single-byte frame is legal (tx_last_i=1 on the first byte).
- Frame length is unbounded.

Test Plan:
- Reset: hold reset_ni=0 → sck=0, cs_n=1, tx=0, busy=0; after release, tx_ready_o=1.
- Single byte 0xA5, last=1, spi_rx_i looped to spi_tx_o → 8 rising edges with SCK period 4 clk (HALF=2); bits on tx are 1,0,1,0,0,1,0,1; rx_valid_o pulses once with rx_data_o=0xA5; CS_N rises HALF cycles after the last falling edge, then stays high ≥4 clk.
- Four-byte write frame 0x40, 0x01, 0xE8, 0x0F (last on 0x0F) → CS_N continuously low for 32 rising edges; four rx strobes; exactly one CS_N rise at the end.
- Stall: after the first byte, withhold tx_valid_i for 10 cycles → SCK stays 0 and CS_N stays 0 throughout; on resume the next byte shifts correctly, with SETUP of HALF cycles before its first edge.
- Receive: send 0x00 while a slave model drives 0x3C MSB-first, changing on falling edges → rx_data_o=0x3C.
- Reset mid-frame: assert reset_ni during bit 4 of byte 2 → cs_n=1 and sck=0 asynchronously, no rx_valid_o; a fresh frame afterwards works normally.
